// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL configuration/lock controller.
package pll_ctrl_pkg;

    // Controller sequence: wait for config, apply it, let the PLL settle,
    // qualify lock, then either run locked or park in the failure state.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        APPLY     = 3'd1,
        SETTLE    = 3'd2,
        WAIT_LOCK = 3'd3,
        LOCKED    = 3'd4,
        FAIL      = 3'd5
    } pll_ctrl_state_e;

    // Divider values driven to the PLL out of reset (unity ratios).
    localparam logic [7:0]  REFDIV_DEFAULT = 8'd1;
    localparam logic [15:0] FBDIV_DEFAULT  = 16'd1;
    localparam logic [7:0]  FDIV_DEFAULT   = 8'd1;

    // A divider of zero would stall the PLL, so such configs are refused.
    function automatic logic cfg_is_legal(input logic [7:0]  refdiv,
                                          input logic [15:0] fbdiv,
                                          input logic [7:0]  fdiv);
        return (refdiv != 8'd0) && (fbdiv != 16'd0) && (fdiv != 8'd0);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock indication into the clk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_ctrl.sv
// PLL controller: accepts divider configs, sequences apply/settle/lock
// qualification, reports lock, loss of lock and lock-timeout failure.
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int STABLE_CYCLES = 32,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [7:0]  cfg_refdiv_i,
    input  logic [15:0] cfg_fbdiv_i,
    input  logic [7:0]  cfg_fdiv_i,
    output logic [7:0]  refdiv_o,
    output logic [15:0] fbdiv_o,
    output logic [7:0]  fdiv_o,
    output logic        bypass_o,
    input  logic        lock_i,
    input  logic        force_bypass_i,
    output logic        locked_o,
    output logic        error_o,
    output logic        cfg_err_o,
    output logic        lock_lost_o
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W     = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]     TO_MAX      = TO_W'(LOCK_TIMEOUT);

    pll_ctrl_state_e state_q;
    pll_ctrl_state_e state_d;

    logic                lock_s;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic [SETTLE_W-1:0] settle_inc;
    logic [STABLE_W-1:0] stable_cnt_q;
    logic [STABLE_W-1:0] stable_inc;
    logic [TO_W-1:0]     timeout_cnt_q;
    logic [TO_W-1:0]     timeout_inc;

    logic [7:0]  refdiv_q;
    logic [15:0] fbdiv_q;
    logic [7:0]  fdiv_q;
    logic        error_q;
    logic        cfg_err_q;
    logic        lock_lost_q;

    logic cfg_fire;
    logic cfg_ok;
    logic load_cfg;
    logic cfg_err_d;
    logic lock_lost_d;

    // Lock from the PLL is asynchronous; only the synchronized copy is used.
    pll_lock_sync u_lock_sync (
        .clk   (clk_i),
        .rst_n (arst_ni),
        .d     (lock_i),
        .q     (lock_s)
    );

    assign cfg_ready_o = (state_q == IDLE) || (state_q == LOCKED) || (state_q == FAIL);
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign cfg_ok      = cfg_is_legal(cfg_refdiv_i, cfg_fbdiv_i, cfg_fdiv_i);

    // Saturating increments so no counter can ever wrap.
    assign settle_inc  = (settle_cnt_q == SETTLE_MAX)  ? settle_cnt_q  : settle_cnt_q  + SETTLE_W'(1);
    assign stable_inc  = (stable_cnt_q == STABLE_MAX)  ? stable_cnt_q  : stable_cnt_q  + STABLE_W'(1);
    assign timeout_inc = (timeout_cnt_q == TO_MAX)     ? timeout_cnt_q : timeout_cnt_q + TO_W'(1);

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and one-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        load_cfg    = 1'b0;
        cfg_err_d   = 1'b0;
        lock_lost_d = 1'b0;
        case (state_q)
            IDLE, FAIL: begin
                if (cfg_fire) begin
                    if (cfg_ok) begin
                        load_cfg = 1'b1;
                        state_d  = APPLY;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            APPLY: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock qualification completing on the timeout cycle wins.
                if (lock_s && (stable_inc == STABLE_MAX)) begin
                    state_d = LOCKED;
                end else if (timeout_inc == TO_MAX) begin
                    state_d = FAIL;
                end
            end
            LOCKED: begin
                // A new config takes precedence over a coincident lock drop.
                if (cfg_fire) begin
                    if (cfg_ok) begin
                        load_cfg = 1'b1;
                        state_d  = APPLY;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = WAIT_LOCK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Settle, stable-lock and timeout counters; each clears outside its state.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            settle_cnt_q  <= '0;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            settle_cnt_q  <= (state_q == SETTLE) ? settle_inc : '0;
            if (state_q == WAIT_LOCK) begin
                stable_cnt_q  <= lock_s ? stable_inc : '0;
                timeout_cnt_q <= timeout_inc;
            end else begin
                stable_cnt_q  <= '0;
                timeout_cnt_q <= '0;
            end
        end
    end

    // Divider registers: only an accepted, legal config changes them.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            refdiv_q <= REFDIV_DEFAULT;
            fbdiv_q  <= FBDIV_DEFAULT;
            fdiv_q   <= FDIV_DEFAULT;
        end else if (load_cfg) begin
            refdiv_q <= cfg_refdiv_i;
            fbdiv_q  <= cfg_fbdiv_i;
            fdiv_q   <= cfg_fdiv_i;
        end
    end

    // Status flags: sticky failure plus single-cycle event pulses.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            error_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            if (load_cfg) begin
                error_q <= 1'b0;
            end else if (state_d == FAIL) begin
                error_q <= 1'b1;
            end
            cfg_err_q   <= cfg_err_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign refdiv_o    = refdiv_q;
    assign fbdiv_o     = fbdiv_q;
    assign fdiv_o      = fdiv_q;
    assign locked_o    = (state_q == LOCKED);
    assign bypass_o    = (state_q == LOCKED) ? force_bypass_i : 1'b1;
    assign error_o     = error_q;
    assign cfg_err_o   = cfg_err_q;
    assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// Scoreboard bench for pll_ctrl with short settle/stable/timeout parameters.
module tb_pll_ctrl;

    localparam int SETTLE  = 4;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 100;

    localparam int EV_LOCK   = 0;
    localparam int EV_LOST   = 1;
    localparam int EV_CFGERR = 2;
    localparam int EV_ERROR  = 3;

    typedef struct {
        int          kind;
        int          lo;
        int          hi;
        logic [7:0]  r;
        logic [15:0] f;
        logic [7:0]  d;
        logic        byp;
    } exp_t;

    exp_t sb_q[$];

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [7:0]  cfg_refdiv_i = 8'd0;
    logic [15:0] cfg_fbdiv_i = 16'd0;
    logic [7:0]  cfg_fdiv_i = 8'd0;
    logic [7:0]  refdiv_o;
    logic [15:0] fbdiv_o;
    logic [7:0]  fdiv_o;
    logic        bypass_o;
    logic        lock_i = 1'b0;
    logic        force_bypass_i = 1'b0;
    logic        locked_o;
    logic        error_o;
    logic        cfg_err_o;
    logic        lock_lost_o;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    pll_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_refdiv_i   (cfg_refdiv_i),
        .cfg_fbdiv_i    (cfg_fbdiv_i),
        .cfg_fdiv_i     (cfg_fdiv_i),
        .refdiv_o       (refdiv_o),
        .fbdiv_o        (fbdiv_o),
        .fdiv_o         (fdiv_o),
        .bypass_o       (bypass_o),
        .lock_i         (lock_i),
        .force_bypass_i (force_bypass_i),
        .locked_o       (locked_o),
        .error_o        (error_o),
        .cfg_err_o      (cfg_err_o),
        .lock_lost_o    (lock_lost_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_refdiv"}, 32'(refdiv_o), 32'd1);
        chk({name, "_fbdiv"},  32'(fbdiv_o),  32'd1);
        chk({name, "_fdiv"},   32'(fdiv_o),   32'd1);
        chk({name, "_bypass"}, 32'(bypass_o), 32'd1);
        chk({name, "_ready"},  32'(cfg_ready_o), 32'd1);
        chk({name, "_locked"}, 32'(locked_o), 32'd0);
        chk({name, "_error"},  32'(error_o),  32'd0);
    endtask

    task automatic push_exp(input int kind, input int lo, input int hi,
                            input logic [7:0] r, input logic [15:0] f,
                            input logic [7:0] d, input logic byp);
        exp_t e;
        e.kind = kind; e.lo = lo; e.hi = hi;
        e.r = r; e.f = f; e.d = d; e.byp = byp;
        sb_q.push_back(e);
    endtask

    // Monitor: every DUT event pops one expectation and is compared against it.
    task automatic check_event(input int kind);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d at cyc=%0d, expected no event", kind, cyc);
            return;
        end
        e = sb_q.pop_front();
        if (e.kind != kind || cyc < e.lo || cyc > e.hi || refdiv_o !== e.r ||
            fbdiv_o !== e.f || fdiv_o !== e.d || bypass_o !== e.byp) begin
            errors++;
            $display("FAIL event got kind=%0d cyc=%0d div=%0d/%0d/%0d byp=%0b expected kind=%0d cyc=[%0d,%0d] div=%0d/%0d/%0d byp=%0b",
                     kind, cyc, refdiv_o, fbdiv_o, fdiv_o, bypass_o,
                     e.kind, e.lo, e.hi, e.r, e.f, e.d, e.byp);
        end
    endtask

    logic prev_locked = 1'b0;
    logic prev_error  = 1'b0;

    always @(negedge clk_i) begin
        if (arst_ni) begin
            if (locked_o && !prev_locked) check_event(EV_LOCK);
            if (lock_lost_o)              check_event(EV_LOST);
            if (cfg_err_o)                check_event(EV_CFGERR);
            if (error_o && !prev_error)   check_event(EV_ERROR);
        end
        prev_locked = locked_o;
        prev_error  = error_o;
    end

    task automatic send_cfg(input logic [7:0] r, input logic [15:0] f,
                            input logic [7:0] d, output int t);
        @(negedge clk_i);
        cfg_valid_i  = 1'b1;
        cfg_refdiv_i = r;
        cfg_fbdiv_i  = f;
        cfg_fdiv_i   = d;
        @(posedge clk_i);
        #1;
        t = cyc;
        cfg_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timed out, pending=%0d expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int lt;

        // Reset and idle behaviour.
        repeat (3) @(posedge clk_i);
        #1;
        check_idle("in_reset");
        @(negedge clk_i);
        arst_ni = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        check_idle("idle_no_cfg");

        // Illegal config while idle: error pulse, nothing else moves.
        send_cfg(8'd0, 16'd10, 8'd1, t);
        push_exp(EV_CFGERR, t, t, 8'd1, 16'd1, 8'd1, 1'b1);
        wait_drain("cfgerr_idle", 5);
        check_idle("after_reject_idle");

        // Normal lock: lock_i rises as the settle window ends.
        send_cfg(8'd2, 16'd50, 8'd4, t);
        chk("apply_refdiv", 32'(refdiv_o), 32'd2);
        chk("apply_fbdiv",  32'(fbdiv_o),  32'd50);
        chk("apply_fdiv",   32'(fdiv_o),   32'd4);
        chk("apply_bypass", 32'(bypass_o), 32'd1);
        chk("apply_ready",  32'(cfg_ready_o), 32'd0);
        push_exp(EV_LOCK, t + 14, t + 16, 8'd2, 16'd50, 8'd4, 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        lock_i = 1'b1;
        wait_drain("lock", 40);
        chk("locked_flag",   32'(locked_o), 32'd1);
        chk("locked_bypass", 32'(bypass_o), 32'd0);
        chk("locked_ready",  32'(cfg_ready_o), 32'd1);

        // Software bypass override while locked.
        force_bypass_i = 1'b1;
        #1;
        chk("force_bypass_on", 32'(bypass_o), 32'd1);
        force_bypass_i = 1'b0;
        #1;
        chk("force_bypass_off", 32'(bypass_o), 32'd0);

        // Zero feedback divider while locked is refused.
        send_cfg(8'd3, 16'd0, 8'd5, t);
        push_exp(EV_CFGERR, t, t, 8'd2, 16'd50, 8'd4, 1'b0);
        wait_drain("cfgerr_locked", 5);
        chk("reject_fbdiv", 32'(fbdiv_o), 32'd50);
        chk("reject_ready", 32'(cfg_ready_o), 32'd1);
        chk("reject_locked", 32'(locked_o), 32'd1);

        // Lock drops for 3 cycles: one loss pulse, then relock with same config.
        @(posedge clk_i);
        #1;
        lt = cyc;
        lock_i = 1'b0;
        push_exp(EV_LOST, lt + 2, lt + 4, 8'd2, 16'd50, 8'd4, 1'b1);
        push_exp(EV_LOCK, lt + 12, lt + 14, 8'd2, 16'd50, 8'd4, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        lock_i = 1'b1;
        wait_drain("relock", 40);
        chk("relock_flag", 32'(locked_o), 32'd1);

        // Config lands on the same edge the synchronized lock drops: no loss
        // pulse. lock_i then stays low so the attempt times out.
        @(posedge clk_i);
        #1;
        lock_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        send_cfg(8'd3, 16'd60, 8'd2, t);
        chk("prio_locked", 32'(locked_o), 32'd0);
        push_exp(EV_ERROR, t + 105, t + 105, 8'd3, 16'd60, 8'd2, 1'b1);
        wait_drain("timeout", 150);
        chk("fail_error",  32'(error_o),  32'd1);
        chk("fail_bypass", 32'(bypass_o), 32'd1);
        chk("fail_locked", 32'(locked_o), 32'd0);
        chk("fail_ready",  32'(cfg_ready_o), 32'd1);

        // Illegal config in failure keeps the error latched.
        send_cfg(8'd5, 16'd5, 8'd0, t);
        push_exp(EV_CFGERR, t, t, 8'd3, 16'd60, 8'd2, 1'b1);
        wait_drain("cfgerr_fail", 5);
        chk("fail_reject_error", 32'(error_o), 32'd1);
        chk("fail_reject_fdiv",  32'(fdiv_o),  32'd2);

        // New config clears the error; toggling lock never qualifies.
        send_cfg(8'd4, 16'd20, 8'd8, t);
        chk("clear_error",  32'(error_o),  32'd0);
        chk("new_fbdiv",    32'(fbdiv_o),  32'd20);
        chk("new_bypass",   32'(bypass_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            lock_i = ~lock_i;
            repeat (4) @(posedge clk_i);
            #1;
        end
        chk("toggle_locked", 32'(locked_o), 32'd0);
        chk("toggle_ready",  32'(cfg_ready_o), 32'd0);

        // Asynchronous reset in the middle of lock qualification.
        #2;
        arst_ni = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk_i);
        arst_ni = 1'b1;
        lock_i  = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        check_idle("after_reset_release");

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_ctrl.md
PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles after divider update during which lock is ignored.
REQ-002 SHALL have parameter STABLE_CYCLES, default 32: consecutive synchronized-lock cycles required to declare lock.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: max cycles in WAIT_LOCK before failure; counter width = $clog2(LOCK_TIMEOUT+1).
REQ-004 SHALL have ports: clk_i in 1 system clock; arst_ni in 1 async active-low reset.
REQ-005 SHALL have ports: cfg_valid_i in 1, cfg_ready_o out 1, cfg_refdiv_i in 8, cfg_fbdiv_i in 16, cfg_fdiv_i in 8 (new-config handshake).
REQ-006 SHALL have ports: refdiv_o out 8, fbdiv_o out 16, fdiv_o out 8, bypass_o out 1 (drive the PLL).
REQ-007 SHALL have ports: lock_i in 1 (PLL lock, asynchronous to clk_i), force_bypass_i in 1 (software bypass override).
REQ-008 SHALL have ports: locked_o out 1, error_o out 1 (sticky), cfg_err_o out 1 (pulse), lock_lost_o out 1 (pulse).

Function
REQ-009 SHALL synchronize lock_i through a 2-flop synchronizer; all decisions use the synchronized value lock_s.
REQ-010 SHALL implement states IDLE, APPLY, SETTLE, WAIT_LOCK, LOCKED, FAIL.
REQ-011 SHALL assert cfg_ready_o only in IDLE, LOCKED and FAIL; a transfer occurs when cfg_valid_i && cfg_ready_o at a rising edge.
REQ-012 SHALL reject a transfer with any of refdiv/fbdiv/fdiv equal to 0: pulse cfg_err_o 1 cycle, keep state and outputs unchanged.
REQ-013 SHALL, on a valid transfer, register the three dividers, clear error_o, clear locked_o, drive bypass_o=1, and enter APPLY next cycle.
REQ-014 SHALL drive refdiv_o/fbdiv_o/fdiv_o from the registered config; they change only on a valid transfer.
REQ-015 SHALL spend exactly 1 cycle in APPLY, then SETTLE for exactly SETTLE_CYCLES cycles, then WAIT_LOCK.
REQ-016 SHALL, in WAIT_LOCK, count consecutive lock_s=1 cycles (reset to 0 on lock_s=0) and a total-cycle timeout counter.
REQ-017 SHALL enter LOCKED when the stable count reaches STABLE_CYCLES; if timeout count reaches LOCK_TIMEOUT first, enter FAIL; stable wins on the same cycle.
REQ-018 SHALL, in LOCKED, drive locked_o=1 and bypass_o=force_bypass_i.
REQ-019 SHALL, if lock_s falls in LOCKED, pulse lock_lost_o 1 cycle, drive bypass_o=1 and locked_o=0 on the next cycle, and re-enter WAIT_LOCK with counters cleared and config unchanged.
REQ-020 SHALL, in FAIL, hold bypass_o=1, locked_o=0, error_o=1 until the next valid transfer.
REQ-021 SHALL hold bypass_o=1 in every state other than LOCKED.
REQ-022 SHALL give a valid transfer in LOCKED priority over a simultaneous lock_s drop (go to APPLY, no lock_lost_o pulse).
REQ-023 SHALL saturate all counters; no wrap-around.

Reset
REQ-024 SHALL, on arst_ni low, asynchronously enter IDLE with refdiv_o=1, fbdiv_o=1, fdiv_o=1, bypass_o=1, locked_o=0, error_o=0, cfg_err_o=0, lock_lost_o=0, counters and synchronizer cleared.
REQ-025 SHALL, on reset mid-lock-sequence, abandon the sequence; no config is retained.
REQ-026 SHALL leave IDLE only via a valid transfer.

Structure
REQ-027 SHALL place the state enum (pll_ctrl_state_e) and default divider constants in package pll_ctrl_pkg.
REQ-028 SHALL instantiate sub-module pll_lock_sync (2-flop synchronizer with async active-low reset) for lock_i.
REQ-029 SHALL be synthesizable, with a single clock domain on clk_i.

Verification (SETTLE_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=100)
REQ-030 Reset released, no cfg -> bypass_o=1, dividers 1/1/1, cfg_ready_o=1, locked_o=0 indefinitely.
REQ-031 Cfg 2/50/4, lock_i held 1 -> dividers updated next cycle; locked_o=1, bypass_o=0 exactly 1+4+(2 sync)+8 cycles after the transfer, within ±1 cycle of the sync-edge alignment.
REQ-032 Cfg 2/50/4, lock_i held 0 -> FAIL after 1+4+100 cycles, error_o=1, bypass_o=1; a new cfg clears error_o.
REQ-033 Cfg with fbdiv=0 -> cfg_err_o 1-cycle pulse, dividers unchanged, cfg_ready_o stays 1.
REQ-034 In LOCKED, lock_i drops for 3 cycles -> single lock_lost_o pulse, bypass_o=1, relock after 8 stable cycles, no config change.
REQ-035 arst_ni asserted in WAIT_LOCK -> immediate IDLE with reset values; lock_i toggling 1/0 every 4 cycles in WAIT_LOCK never yields locked_o.
